// File: rtl/wb_master_bridge_if.sv
// Wishbone pipelined-mode bus between the CPU bridge (master) and a peripheral (slave).
// Member names follow the master's point of view: o_* are driven by the master.
interface wb_master_bridge_if #(
  parameter int unsigned AW = 2
);
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_ack;
  logic          i_wb_stall;
  logic          i_wb_err;
  logic [31:0]   i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-outstanding CPU-to-Wishbone (pipelined) bridge with timeout abort,
// sticky timeout flag and a saturating error counter. Every output is a flop.
module wb_master_bridge #(
  parameter int unsigned AW        = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [AW-1:0]         cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_err,
  wb_master_bridge_if.master    wb,
  input  logic                  clr,
  output logic                  busy,
  output logic [7:0]            err_cnt,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    sel_q, sel_d;
  logic          ready_q, ready_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [16:0]   tcnt_inc;
  logic          expired, bump, tmo;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          tflag_q, tflag_d, busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready_d   = 1'b0;
    tcnt_d    = tcnt_q;
    bump      = 1'b0;
    tmo       = 1'b0;
    tcnt_inc  = {1'b0, tcnt_q} + 17'd1;
    expired   = (tcnt_inc >= TO_LIM);

    case (state_q)
      IDLE: begin
        // ready_q still high means cpu_valid belongs to the request just answered
        if (cpu_valid && !ready_q) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          data_d  = cpu_wdata;
          sel_d   = (!cpu_we || cpu_wstrb == 4'b0000) ? 4'b1111 : cpu_wstrb;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        if (state_q == WAIT && wb.i_wb_err) begin
          cyc_d   = 1'b0;
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          bump    = 1'b1;
          state_d = DONE;
        end else if (state_q == WAIT && wb.i_wb_ack) begin
          cyc_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : wb.i_wb_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (expired) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          bump    = 1'b1;
          tmo     = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_inc[15:0];
          if (state_q == REQ && !wb.i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = clr ? 8'd0 : (bump ? sat_inc8(err_cnt_q) : err_cnt_q);
    tflag_d   = clr ? 1'b0 : (tflag_q | tmo);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      tcnt_q    <= '0;
      err_cnt_q <= '0;
      tflag_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      tcnt_q    <= tcnt_d;
      err_cnt_q <= err_cnt_d;
      tflag_q   <= tflag_d;
      busy_q    <= busy_d;
    end
  end

  assign wb.o_wb_cyc  = cyc_q;
  assign wb.o_wb_stb  = stb_q;
  assign wb.o_wb_we   = we_q;
  assign wb.o_wb_addr = addr_q;
  assign wb.o_wb_data = data_q;
  assign wb.o_wb_sel  = sel_q;
  assign cpu_ready    = ready_q;
  assign cpu_rdata    = rdata_q;
  assign cpu_err      = err_q;
  assign busy         = busy_q;
  assign err_cnt      = err_cnt_q;
  assign timeout_flag = tflag_q;

endmodule
